// File: rtl/regfile_8x16c_if.sv
// regfile_8x16c_if: write/read bus for the 8x16 register file.
//   write   - write enable, sampled on rising clk edge
//   wrAddr  - write address (ADDR_W bits)
//   wrData  - write data (DATA_W bits)
//   rdAddrA - read address, port A;  rdDataA - read data, port A
//   rdAddrB - read address, port B;  rdDataB - read data, port B
// master: decode/write-back side driving addresses and data.
// slave:  the register file itself.
interface regfile_8x16c_if;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;

    logic              write;
    logic [ADDR_W-1:0] wrAddr;
    logic [DATA_W-1:0] wrData;
    logic [ADDR_W-1:0] rdAddrA;
    logic [DATA_W-1:0] rdDataA;
    logic [ADDR_W-1:0] rdAddrB;
    logic [DATA_W-1:0] rdDataB;

    modport master (
        output write, wrAddr, wrData, rdAddrA, rdAddrB,
        input  rdDataA, rdDataB
    );

    modport slave (
        input  write, wrAddr, wrData, rdAddrA, rdAddrB,
        output rdDataA, rdDataB
    );
endinterface

// File: rtl/regfile_8x16c.sv
// regfile_8x16c: 8 x 16-bit general-purpose register file.
// One synchronous write port, two independent combinational read ports.
// Ports:
//   clk   - system clock, state updates on rising edge
//   reset - asynchronous active-high reset, clears every register
//   bus   - regfile_8x16c_if.slave (write port + read ports A/B)
// Build option:
//   REGFILE_BYPASS_EN - when defined, each read port forwards wrData in the
//   same cycle when it addresses the register being written. Storage update
//   is identical either way.
module regfile_8x16c (
    input  logic              clk,
    input  logic              reset,
    regfile_8x16c_if.slave    bus
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs;

    // Storage: async clear, write on rising edge when enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs <= '0;
        end else if (bus.write) begin
            regs[bus.wrAddr] <= bus.wrData;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic hitA;
    logic hitB;

    // Write-through forwarding, per port; suppressed while reset holds storage clear.
    always_comb begin
        hitA = !reset && bus.write && (bus.rdAddrA == bus.wrAddr);
        hitB = !reset && bus.write && (bus.rdAddrB == bus.wrAddr);
        bus.rdDataA = hitA ? bus.wrData : regs[bus.rdAddrA];
        bus.rdDataB = hitB ? bus.wrData : regs[bus.rdAddrB];
    end
`else
    // Plain array read: same-cycle reads see the old contents.
    always_comb begin
        bus.rdDataA = regs[bus.rdAddrA];
        bus.rdDataB = regs[bus.rdAddrB];
    end
`endif
endmodule

// File: tb/tb_regfile_8x16c.sv
// tb_regfile_8x16c: self-checking bench for regfile_8x16c using a
// reference array and an expected-value queue.
module tb_regfile_8x16c;
    logic clk;
    logic reset;
    regfile_8x16c_if bus ();

    regfile_8x16c dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checkCnt = 0;
    int unsigned errCnt   = 0;
    logic [15:0] model [8];
    logic [15:0] expQ [$];

    task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checkCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Push expectations, settle, then pop and compare both ports.
    task automatic readNow(input string tag, input logic [2:0] a, input logic [2:0] b,
                           input logic [15:0] expA, input logic [15:0] expB);
        bus.rdAddrA = a;
        bus.rdAddrB = b;
        expQ.push_back(expA);
        expQ.push_back(expB);
        #1;
        checkVal({tag, "_A"}, bus.rdDataA, expQ.pop_front());
        checkVal({tag, "_B"}, bus.rdDataB, expQ.pop_front());
    endtask

    // Read both ports against the reference model, mid low phase.
    task automatic readCheck(input string tag, input logic [2:0] a, input logic [2:0] b);
        @(negedge clk);
        readNow(tag, a, b, model[a], model[b]);
    endtask

    task automatic doWrite(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.write  = 1'b1;
        bus.wrAddr = a;
        bus.wrData = d;
        @(posedge clk);
        if (!reset) model[a] = d;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] d;
        logic [2:0]  a;
        reset       = 1'b1;
        bus.write   = 1'b0;
        bus.wrAddr  = '0;
        bus.wrData  = '0;
        bus.rdAddrA = '0;
        bus.rdAddrB = '0;
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;

        // Reset state, and a write attempted under reset is ignored.
        for (int i = 0; i < 8; i++) readCheck("rst_init", 3'(i), 3'(7 - i));
        doWrite(3'd3, 16'hBEEF);
        readCheck("rst_wr_ignored", 3'd3, 3'd3);
        @(negedge clk);
        reset = 1'b0;

        // Fill and read back with opposing sweeps.
        for (int i = 0; i < 8; i++) doWrite(3'(i), 16'(16'h1111 * (i + 1)));
        for (int i = 0; i < 8; i++) readCheck("fill", 3'(i), 3'(7 - i));
        checkVal("fill_model7", model[7], 16'h8888);

        // Overwrite with wrap: iterations 8..15 win.
        for (int i = 0; i < 16; i++) begin
            a = 3'(i);
            d = 16'($urandom);
            doWrite(a, d);
        end
        for (int i = 0; i < 8; i++) readCheck("wrap", 3'(i), 3'(7 - i));

        // Hold: write disabled, data/address presented.
        @(negedge clk);
        bus.write  = 1'b0;
        bus.wrAddr = 3'd4;
        bus.wrData = 16'hFFFF;
        for (int i = 0; i < 5; i++) readCheck("hold", 3'd4, 3'd4);

        // Same-address read during write.
        doWrite(3'd4, 16'hAAAA);
        @(negedge clk);
        bus.write  = 1'b1;
        bus.wrAddr = 3'd4;
        bus.wrData = 16'h0005;
`ifdef REGFILE_BYPASS_EN
        readNow("rdw_pre", 3'd4, 3'd4, 16'h0005, 16'h0005);
`else
        readNow("rdw_pre", 3'd4, 3'd4, 16'hAAAA, 16'hAAAA);
`endif
        @(posedge clk);
        model[4] = 16'h0005;
        #1;
        readNow("rdw_post", 3'd4, 3'd4, 16'h0005, 16'h0005);
        @(negedge clk);
        bus.write = 1'b0;

        // Dual-port independence while writing another address.
        @(negedge clk);
        bus.write  = 1'b1;
        bus.wrAddr = 3'd3;
        bus.wrData = 16'h3C3C;
        readNow("dual_pre", 3'd2, 3'd6, model[2], model[6]);
        @(posedge clk);
        model[3] = 16'h3C3C;
        #1;
        readNow("dual_post", 3'd2, 3'd6, model[2], model[6]);
        @(negedge clk);
        bus.write = 1'b0;
        readCheck("dual_new", 3'd3, 3'd2);

        // Last write wins on back-to-back same-address writes.
        doWrite(3'd1, 16'h1234);
        doWrite(3'd1, 16'h5678);
        readCheck("last_wins", 3'd1, 3'd1);

        // Mid-cycle async reset clears everything immediately.
        @(negedge clk);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        readNow("rst_async", 3'd1, 3'd4, 16'h0000, 16'h0000);
        for (int i = 0; i < 8; i++) readCheck("rst_mid", 3'(i), 3'(7 - i));
        doWrite(3'd5, 16'h7777);
        readCheck("rst_mid_wr", 3'd5, 3'd5);
        @(negedge clk);
        reset = 1'b0;
        doWrite(3'd5, 16'h7777);
        readCheck("post_rst_wr", 3'd5, 3'd0);

        checkVal("queue_empty", 16'(expQ.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
        $finish;
    end
endmodule
